// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator (pixel enable, syncs, coordinates, strobes)
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int CW       = 10
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          run_i,
    output logic          pix_en_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          active_o,
    output logic          blank_n_o,
    output logic [CW-1:0] xaddr_o,
    output logic [CW-1:0] yaddr_o,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic [7:0]    frame_count_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Divider needs at least one bit even when every clk is a pixel clk.
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    // Sync windows expressed as [begin, end) so the end bound stays inside the line.
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [DW-1:0] div_q,         div_d;
    logic [CW-1:0] h_q,           h_d;
    logic [CW-1:0] v_q,           v_d;
    logic          pix_en_q,      pix_en_d;
    logic          hsync_q,       hsync_d;
    logic          vsync_q,       vsync_d;
    logic          active_q,      active_d;
    logic          line_start_q,  line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    frame_cnt_q,   frame_cnt_d;
    logic          step;

    // Next-state: advance divider/counters and decode every output from the next count.
    always_comb begin
        step          = 1'b0;
        div_d         = '0;
        h_d           = H_LAST;
        v_d           = V_LAST;
        pix_en_d      = 1'b0;
        hsync_d       = ~HS_ON;
        vsync_d       = ~VS_ON;
        active_d      = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = '0;
        if (run_i) begin
            step        = (div_q == DIV_LAST);
            div_d       = step ? '0 : (div_q + DIV_ONE);
            h_d         = h_q;
            v_d         = v_q;
            if (step) begin
                if (h_q == H_LAST) begin
                    h_d = '0;
                    v_d = (v_q == V_LAST) ? '0 : (v_q + C_ONE);
                end else begin
                    h_d = h_q + C_ONE;
                end
            end
            pix_en_d      = step;
            line_start_d  = step && (h_d == '0);
            frame_start_d = line_start_d && (v_d == '0);
            frame_cnt_d   = frame_cnt_q + {7'd0, frame_start_d};
            hsync_d       = ((h_d >= HS_BEG) && (h_d < HS_END)) ? HS_ON : ~HS_ON;
            vsync_d       = ((v_d >= VS_BEG) && (v_d < VS_END)) ? VS_ON : ~VS_ON;
            active_d      = (h_d < H_ACT) && (v_d < V_ACT);
        end
    end

    // State and output registers; run=0 lands in the same state as reset via the next-state defaults.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q         <= '0;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            pix_en_q      <= 1'b0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            pix_en_q      <= pix_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_en_o      = pix_en_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign active_o      = active_q;
    assign blank_n_o     = active_q;
    assign xaddr_o       = h_q;
    assign yaddr_o       = v_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;
    assign frame_count_o = frame_cnt_q;

endmodule
